// File: rtl/req_fifo_arbiter.sv
// Round-robin arbiter feeding a DEPTH-entry request FIFO with a valid/ready drain and flush.
// Define ARB_PRIO_EN to add prio_i: high-priority requesters are arbitrated first.
module req_fifo_arbiter #(
    parameter int NREQ      = 2,
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid_i,
    input  logic [NREQ*DATA_SIZE-1:0]  req_data_i,
`ifdef ARB_PRIO_EN
    input  logic [NREQ-1:0]            prio_i,
`endif
    output logic [NREQ-1:0]            req_ready_o,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    output logic [DATA_SIZE-1:0]       out_data_o,
    output logic [$clog2(NREQ)-1:0]    out_id_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int EW  = IDW + DATA_SIZE;

    logic [EW-1:0]        mem_q [DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;

    logic                 pop;
    logic                 push;
    logic                 can_push;
    logic [NREQ-1:0]      cand;
    logic [NREQ-1:0]      upper_mask;
    logic [NREQ-1:0]      masked;
    logic [NREQ-1:0]      pick;
    logic [NREQ-1:0]      one_hot;
    logic [IDW-1:0]       grant_idx;
    logic [DATA_SIZE-1:0] push_data;

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q][DATA_SIZE-1:0];
    assign out_id_o    = mem_q[rd_ptr_q][EW-1 -: IDW];
    assign count_o     = count_q;

    assign pop      = out_valid_o & out_ready_i;
    assign can_push = (count_q != CW'(DEPTH)) | pop;

    // Round-robin: lowest requester at or above rr_ptr wins, else lowest overall.
    always_comb begin
        cand = req_valid_i;
`ifdef ARB_PRIO_EN
        if (|(req_valid_i & prio_i)) begin
            cand = req_valid_i & prio_i;
        end
`endif
        upper_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper_mask[i] = (IDW'(i) >= rr_ptr_q);
        end
        masked  = cand & upper_mask;
        pick    = (|masked) ? masked : cand;
        one_hot = pick & (~pick + NREQ'(1));
    end

    always_comb begin
        grant_idx = '0;
        push_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (one_hot[i]) begin
                grant_idx = IDW'(i);
                push_data = req_data_i[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign req_ready_o = (rst_n && can_push && !flush_i) ? one_hot : '0;
    assign push        = |req_ready_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            // Storage keeps stale data; only the bookkeeping is cleared.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {grant_idx, push_data};
            end
        end
    end

`ifndef SYNTHESIS
    logic [NREQ-1:0]           pend_q;
    logic [NREQ*DATA_SIZE-1:0] data_q;

    always_ff @(posedge clk) begin
        pend_q <= rst_n ? (req_valid_i & ~req_ready_o) : '0;
        data_q <= req_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend_q[i]) begin
                    assert (req_valid_i[i] &&
                            req_data_i[i*DATA_SIZE +: DATA_SIZE] == data_q[i*DATA_SIZE +: DATA_SIZE]);
                end
            end
            assert (!(push && count_q == CW'(DEPTH) && !pop));
            assert (!(pop && count_q == '0));
        end
    end
`endif

endmodule

// File: tb/tb_req_fifo_arbiter.sv
// Directed and random checks of req_fifo_arbiter against a queue-based reference model.
module tb_req_fifo_arbiter;
    localparam int NREQ  = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    prio;
    logic [NREQ-1:0]    req_ready;
    logic               flush;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [0:0]         out_id;
    logic               out_ready;
    logic [2:0]         count;

    int errors = 0;
    int checks = 0;

    int              q_id[$];
    logic [DW-1:0]   q_dat[$];
    int              rr = 0;
    logic [NREQ-1:0] exp_grant = '0;
    logic [NREQ-1:0] last_ready;

    req_fifo_arbiter #(.NREQ(NREQ), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
`ifdef ARB_PRIO_EN
        .prio_i      (prio),
`endif
        .req_ready_o (req_ready),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .out_ready_i (out_ready),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] model_grant();
        logic [NREQ-1:0] pool;
        bit room;
        pool = req_valid;
`ifdef ARB_PRIO_EN
        if (|(req_valid & prio)) pool = req_valid & prio;
`endif
        room = (q_id.size() < DEPTH) || (q_id.size() > 0 && out_ready);
        if (!rst_n || flush || !room) return '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr + k) % NREQ;
            if (pool[idx]) return NREQ'(1) << idx;
        end
        return '0;
    endfunction

    // One clock: check grant mid-cycle, advance model, check registered outputs after the edge.
    task automatic step();
        bit was_reset;
        @(negedge clk);
        exp_grant  = model_grant();
        last_ready = req_ready;
        chk("req_ready", req_ready, exp_grant);
        was_reset = !rst_n;
        if (!rst_n || flush) begin
            q_id.delete();
            q_dat.delete();
            rr = 0;
        end else begin
            if (q_id.size() > 0 && out_ready) begin
                void'(q_id.pop_front());
                void'(q_dat.pop_front());
            end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_grant[i]) begin
                    q_id.push_back(i);
                    q_dat.push_back(req_data[i*DW +: DW]);
                    rr = (i + 1) % NREQ;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("count", count, q_id.size());
        chk("out_valid", out_valid, q_id.size() != 0);
        if (q_id.size() != 0) begin
            chk("out_data", out_data, q_dat[0]);
            chk("out_id", out_id, q_id[0]);
        end else if (was_reset) begin
            chk("rst_out_data", out_data, 0);
            chk("rst_out_id", out_id, 0);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) step();
        rst_n = 1'b1;
    endtask

    task automatic prep_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || exp_grant[i]) begin
                req_valid[i]         = 1'($urandom % 2);
                req_data[i*DW +: DW] = $urandom;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        prio      = '0;
        req_valid = '1;
        req_data  = {32'h1111_0000, 32'h2222_0000};

        // Reset with both requesters valid
        do_reset(3);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);

        // Round-robin alternation, both always valid
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_grant", last_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_out_id", out_id, k % 2);
            for (int i = 0; i < NREQ; i++)
                if (last_ready[i]) req_data[i*DW +: DW] = 32'h100 + k * 2 + i;
        end

        // Fill to full, blocked fifth push, then simultaneous pop+push
        do_reset(1);
        out_ready = 1'b0;
        req_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            req_data[DW-1:0] = 32'hA0 + k;
            step();
        end
        chk("full_count", count, 4);
        req_data[DW-1:0] = 32'hA4;
        step();
        chk("full_block", last_ready, 2'b00);
        out_ready = 1'b1;
        step();
        chk("full_pushpop", last_ready, 2'b01);
        chk("full_count_hold", count, 4);
        chk("full_head", out_data, 32'hA1);

        // Flush with count=3 while requester 1 waits
        do_reset(1);
        out_ready = 1'b0;
        req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            req_data[DW-1:0] = 32'hC0 + k;
            step();
        end
        chk("pre_flush_count", count, 3);
        req_valid = 2'b10;
        req_data[2*DW-1:DW] = 32'h55;
        flush = 1'b1;
        step();
        chk("flush_nogrant", last_ready, 2'b00);
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        flush = 1'b0;
        step();
        chk("post_flush_grant", last_ready, 2'b10);
        chk("post_flush_data", out_data, 32'h55);
        req_valid = 2'b00;
        out_ready = 1'b1;
        step();

        // Pointer wrap with streaming push/pop
        do_reset(1);
        out_ready = 1'b1;
        req_valid = 2'b01;
        for (int k = 0; k < 10; k++) begin
            req_data[DW-1:0] = k;
            step();
            chk("wrap_data", out_data, k);
            chk("wrap_count", count, 1);
        end
        req_valid = 2'b00;
        step();
        chk("wrap_drain", count, 0);

`ifdef ARB_PRIO_EN
        do_reset(1);
        prio      = 2'b10;
        req_valid = 2'b11;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_data[2*DW-1:DW] = 32'hB0 + k;
            step();
            chk("prio_hi", last_ready, 2'b10);
        end
        req_valid[1] = 1'b0;
        step();
        chk("prio_lo", last_ready, 2'b01);
        prio = '0;
`endif

        // Random traffic against the model
        do_reset(1);
        for (int n = 0; n < 400; n++) begin
            prep_reqs();
            out_ready = 1'($urandom % 4 != 0);
            flush     = ($urandom % 16 == 0);
            rst_n     = ($urandom % 64 != 0);
`ifdef ARB_PRIO_EN
            prio = NREQ'($urandom);
`endif
            step();
        end
        rst_n = 1'b1;
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
